trng_collector: RTL and testbench

Post-processing stage directly downstream of the ring-oscillator TRNG macro. It drives the macro's enable and samples its single-bit output every clock. It optionally applies von Neumann debiasing, runs a repetition-count health test, and packs accepted bits into WIDTH-bit words. Finished words are handed to the bus-side register block over a valid/ready handshake with a one-word output buffer.

---
 rtl/trng_pkg.sv | 26 ++
 rtl/trng_vn_debias.sv | 36 +++
 rtl/trng_collector.sv | 227 ++++++++++++++++++++++
 tb/tb_trng_collector.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG post-processing collector.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_STALL   = 3'd3,
        ST_FAULT   = 3'd4
    } trng_coll_state_e;

    localparam int TRNG_WIDTH     = 32;
    localparam int TRNG_WARMUP    = 16;
    localparam int TRNG_REP_LIMIT = 32;

    // The macro is kept running only in the states that consume its output.
    function automatic logic is_run_state(input trng_coll_state_e st);
        logic run;
        case (st)
            ST_WARMUP, ST_COLLECT, ST_STALL: run = 1'b1;
            default:                         run = 1'b0;
        endcase
        return run;
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs raw samples, emits first bit of a 01/10 pair,
// and drops 00/11 pairs.
module trng_vn_debias (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit
);

    logic phase_r;
    logic first_r;

    // Pair phase and first-sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
            first_r <= 1'b0;
        end else if (clr) begin
            phase_r <= 1'b0;
        end else if (in_valid) begin
            if (!phase_r) begin
                first_r <= in_bit;
                phase_r <= 1'b1;
            end else begin
                phase_r <= 1'b0;
            end
        end
    end

    assign out_valid = in_valid & phase_r & (first_r ^ in_bit);
    assign out_bit   = first_r;

endmodule

// File: rtl/trng_collector.sv
// TRNG post-processing: warm-up, optional debiasing, repetition-count health
// test and word packing with a one-word valid/ready output buffer.
module trng_collector
    import trng_pkg::*;
#(
    parameter int WIDTH     = TRNG_WIDTH,
    parameter int WARMUP    = TRNG_WARMUP,
    parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             debias_i,
    output logic             trng_en_o,
    input  logic             trng_bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             fail_o,
    input  logic             clear_fail_i
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int WARM_W = $clog2(WARMUP + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_LIMIT - 1);

    trng_coll_state_e state_r, state_nx_s;
    logic [WARM_W-1:0] warm_cnt_r;
    logic [REP_W-1:0]  rep_cnt_r;
    logic              last_bit_r;
    logic [WIDTH-1:0]  shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  hold_r;
    logic [WIDTH-1:0]  data_r;
    logic              valid_r;
    logic              fail_r;
    logic              trng_en_r;
    logic              debias_r;

    logic              coll_act_s;
    logic              vn_valid_s;
    logic              vn_bit_s;
    logic              acc_valid_s;
    logic              acc_bit_s;
    logic [WIDTH-1:0]  word_s;
    logic              word_done_s;
    logic              trip_s;
    logic              hs_s;
    logic              buf_free_s;

    // A sample only counts while collecting with software enable still high.
    assign coll_act_s  = (state_r == ST_COLLECT) && enable_i;
    assign hs_s        = valid_r && ready_i;
    assign buf_free_s  = !valid_r || hs_s;
    assign trip_s      = coll_act_s && (rep_cnt_r == REP_LAST) && (trng_bit_i == last_bit_r);
    assign word_s      = {shift_r[WIDTH-2:0], acc_bit_s};
    assign word_done_s = acc_valid_s && (cnt_r == CNT_LAST);

    trng_vn_debias u_debias (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_r != ST_COLLECT),
        .in_valid  (coll_act_s && debias_r),
        .in_bit    (trng_bit_i),
        .out_valid (vn_valid_s),
        .out_bit   (vn_bit_s)
    );

    // Select the accepted-bit source for the configured mode.
    always_comb begin
        acc_valid_s = 1'b0;
        acc_bit_s   = 1'b0;
        if (debias_r) begin
            acc_valid_s = vn_valid_s;
            acc_bit_s   = vn_bit_s;
        end else begin
            acc_valid_s = coll_act_s;
            acc_bit_s   = trng_bit_i;
        end
    end

    // Next-state logic; the health trip outranks word completion.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i && !fail_r) begin
                    state_nx_s = ST_WARMUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (!enable_i) begin
                    state_nx_s = ST_IDLE;
                end else if (warm_cnt_r == WARM_LAST) begin
                    state_nx_s = ST_COLLECT;
                end else begin
                    state_nx_s = ST_WARMUP;
                end
            end
            ST_COLLECT: begin
                if (!enable_i) begin
                    state_nx_s = ST_IDLE;
                end else if (trip_s) begin
                    state_nx_s = ST_FAULT;
                end else if (word_done_s && !buf_free_s) begin
                    state_nx_s = ST_STALL;
                end else begin
                    state_nx_s = ST_COLLECT;
                end
            end
            ST_STALL: begin
                if (!enable_i) begin
                    state_nx_s = ST_IDLE;
                end else if (hs_s) begin
                    state_nx_s = ST_COLLECT;
                end else begin
                    state_nx_s = ST_STALL;
                end
            end
            ST_FAULT: begin
                if (clear_fail_i) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FAULT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, macro enable, sticky failure flag and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            trng_en_r <= 1'b0;
            fail_r    <= 1'b0;
            debias_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            trng_en_r <= is_run_state(state_nx_s);
            if (trip_s) begin
                fail_r <= 1'b1;
            end else if ((state_r == ST_FAULT) && clear_fail_i) begin
                fail_r <= 1'b0;
            end
            if ((state_r == ST_IDLE) && (state_nx_s == ST_WARMUP)) begin
                debias_r <= debias_i;
            end
        end
    end

    // Warm-up counter and repetition run length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_r <= {WARM_W{1'b0}};
            rep_cnt_r  <= {REP_W{1'b0}};
            last_bit_r <= 1'b0;
        end else begin
            if (state_r == ST_WARMUP) begin
                warm_cnt_r <= warm_cnt_r + WARM_W'(1);
            end else begin
                warm_cnt_r <= {WARM_W{1'b0}};
            end
            if (coll_act_s) begin
                last_bit_r <= trng_bit_i;
                if ((rep_cnt_r != {REP_W{1'b0}}) && (trng_bit_i == last_bit_r)) begin
                    rep_cnt_r <= rep_cnt_r + REP_W'(1);
                end else begin
                    rep_cnt_r <= REP_W'(1);
                end
            end else begin
                rep_cnt_r <= {REP_W{1'b0}};
            end
        end
    end

    // Shift register, bit count and the word held during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            hold_r  <= {WIDTH{1'b0}};
        end else if (trip_s || (state_r != ST_COLLECT)) begin
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (acc_valid_s) begin
            shift_r <= word_s;
            if (word_done_s) begin
                cnt_r <= {CNT_W{1'b0}};
                if (!buf_free_s) begin
                    hold_r <= word_s;
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Output buffer; a health trip drops any unread word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (trip_s) begin
            valid_r <= 1'b0;
        end else if (word_done_s && buf_free_s) begin
            data_r  <= word_s;
            valid_r <= 1'b1;
        end else if ((state_r == ST_STALL) && enable_i && hs_s) begin
            data_r  <= hold_r;
            valid_r <= 1'b1;
        end else if (hs_s) begin
            valid_r <= 1'b0;
        end
    end

    assign trng_en_o = trng_en_r;
    assign data_o    = data_r;
    assign valid_o   = valid_r;
    assign fail_o    = fail_r;

endmodule

// File: tb/tb_trng_collector.sv
// Directed self-checking bench for trng_collector with default parameters.
module tb_trng_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic        debias_i;
    logic        trng_en_o;
    logic        trng_bit_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        fail_o;
    logic        clear_fail_i;

    int tests_run    = 0;
    int tests_failed = 0;

    trng_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .debias_i     (debias_i),
        .trng_en_o    (trng_en_o),
        .trng_bit_i   (trng_bit_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fail_o       (fail_o),
        .clear_fail_i (clear_fail_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Raise enable at a negedge and return at the negedge before the first COLLECT sample.
    task automatic start_run(input logic dbm);
        enable_i = 1'b1;
        debias_i = dbm;
        repeat (17) @(negedge clk);
    endtask

    task automatic end_run;
        enable_i   = 1'b0;
        ready_i    = 1'b1;
        trng_bit_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable_i = 1'b0; debias_i = 1'b0; trng_bit_i = 1'b0;
        ready_i = 1'b0; clear_fail_i = 1'b0;
        #1;
        tests_run++;
        if ({trng_en_o, valid_o, fail_o, data_o} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got en=%b v=%b f=%b d=%h expected all 0", trng_en_o, valid_o, fail_o, data_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (trng_en_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_en: got %b expected 0", trng_en_o);
        end
    endtask

    task automatic test_raw;
        logic [31:0] w;
        w = 32'hA5A5A5A5;
        ready_i = 1'b1;
        start_run(1'b0);
        tests_run++;
        if (trng_en_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_trng_en: got %b expected 1", trng_en_o);
        end
        for (int i = 0; i < 32; i++) begin
            trng_bit_i = w[31-i];
            @(negedge clk);
            tests_run++;
            if (valid_o !== (i == 31)) begin
                tests_failed++;
                $display("FAIL raw_valid[%0d]: got %b expected %b", i, valid_o, (i == 31));
            end
        end
        tests_run++;
        if (data_o !== 32'hA5A5A5A5 || fail_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_word: got %h fail=%b expected a5a5a5a5 fail=0", data_o, fail_o);
        end
        end_run();
    endtask

    task automatic test_debias;
        logic [7:0] pat;
        logic       exp_v;
        pat = 8'b01100011;
        ready_i = 1'b1;
        start_run(1'b1);
        for (int s = 0; s < 256; s++) begin
            trng_bit_i = pat[7 - (s % 8)];
            @(negedge clk);
            exp_v = (s == 123) || (s == 251);
            tests_run++;
            if (valid_o !== exp_v) begin
                tests_failed++;
                $display("FAIL debias_valid[%0d]: got %b expected %b", s, valid_o, exp_v);
            end
            if (exp_v) begin
                tests_run++;
                if (data_o !== 32'h55555555) begin
                    tests_failed++;
                    $display("FAIL debias_word[%0d]: got %h expected 55555555", s, data_o);
                end
            end
        end
        end_run();
    endtask

    // Two raw words with no consumer: second word waits in STALL.
    task automatic fill_to_stall;
        logic [63:0] w;
        w = 64'h12345678_9ABCDEF0;
        ready_i = 1'b0;
        start_run(1'b0);
        for (int s = 0; s < 64; s++) begin
            trng_bit_i = w[63-s];
            @(negedge clk);
            tests_run++;
            if (valid_o !== (s >= 31)) begin
                tests_failed++;
                $display("FAIL stall_valid[%0d]: got %b expected %b", s, valid_o, (s >= 31));
            end
        end
        trng_bit_i = 1'b0;
    endtask

    task automatic test_backpressure;
        fill_to_stall();
        repeat (3) @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 32'h12345678 || trng_en_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold: got v=%b d=%h en=%b expected v=1 d=12345678 en=1", valid_o, data_o, trng_en_o);
        end
        ready_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 32'h9ABCDEF0) begin
            tests_failed++;
            $display("FAIL bp_second: got v=%b d=%h expected v=1 d=9abcdef0", valid_o, data_o);
        end
        @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: got %b expected 0", valid_o);
        end
        end_run();
    endtask

    task automatic test_health;
        ready_i = 1'b1;
        start_run(1'b0);
        trng_bit_i = 1'b1;
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            tests_run++;
            if (fail_o !== (s == 31)) begin
                tests_failed++;
                $display("FAIL health_fail[%0d]: got %b expected %b", s, fail_o, (s == 31));
            end
        end
        tests_run++;
        if (valid_o !== 1'b0 || trng_en_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL health_trip: got v=%b en=%b expected v=0 en=0", valid_o, trng_en_o);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (fail_o !== 1'b1 || trng_en_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL health_sticky: got f=%b en=%b expected f=1 en=0", fail_o, trng_en_o);
        end
        clear_fail_i = 1'b1;
        @(negedge clk);
        clear_fail_i = 1'b0;
        tests_run++;
        if (fail_o !== 1'b0 || trng_en_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL health_clear: got f=%b en=%b expected f=0 en=0", fail_o, trng_en_o);
        end
        @(negedge clk);
        tests_run++;
        if (trng_en_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL health_restart: got %b expected 1", trng_en_o);
        end
        end_run();
    endtask

    task automatic test_enable_drop;
        logic [31:0] w;
        w = 32'hC3C3C3C3;
        ready_i = 1'b1;
        trng_bit_i = 1'b0;
        enable_i = 1'b1;
        debias_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (trng_en_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_en_rise: got %b expected 1", trng_en_o);
        end
        repeat (16) @(negedge clk);
        for (int s = 0; s < 10; s++) begin
            trng_bit_i = (s % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        enable_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (trng_en_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_en_fall: got %b expected 0", trng_en_o);
        end
        repeat (2) @(negedge clk);
        trng_bit_i = 1'b1;
        start_run(1'b0);
        for (int i = 0; i < 32; i++) begin
            trng_bit_i = w[31-i];
            @(negedge clk);
            tests_run++;
            if (valid_o !== (i == 31)) begin
                tests_failed++;
                $display("FAIL drop_valid[%0d]: got %b expected %b", i, valid_o, (i == 31));
            end
        end
        tests_run++;
        if (data_o !== 32'hC3C3C3C3) begin
            tests_failed++;
            $display("FAIL drop_word: got %h expected c3c3c3c3", data_o);
        end
        end_run();
    endtask

    task automatic test_async_reset;
        fill_to_stall();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({trng_en_o, valid_o, fail_o, data_o} !== 35'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got en=%b v=%b f=%b d=%h expected all 0", trng_en_o, valid_o, fail_o, data_o);
        end
        enable_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        enable_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (trng_en_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_idle_restart: got en=%b v=%b expected en=1 v=0", trng_en_o, valid_o);
        end
        end_run();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_debias();
        test_backpressure();
        test_health();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
